// File: rtl/spi_flash_pkg.sv
// Shared SPI flash definitions for the W25Q32 read (SPILoader) and write-back paths.
package spi_flash_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_READ = 8'h03;

    localparam int unsigned PAGE_SIZE = 256;

    typedef enum logic [2:0] {
        IDLE,
        WREN,
        GAP1,
        PP,
        GAP2,
        POLL,
        FIN
    } state_e;

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte engine: SCK divider, MSB-first MOSI shift-out, MISO shift-in.
module spi_byte_shifter #(
    parameter int unsigned SCK_HALF = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] tx_byte_i,
    input  logic       miso_i,
    output logic       sck_o,
    output logic       mosi_o,
    output logic       byte_done_o,
    output logic [7:0] rx_byte_o
);

    localparam int unsigned DivW = $clog2(SCK_HALF) + 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCK_HALF - 1);

    logic            active_q, active_d;
    logic            sck_q, sck_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;
    logic            half_end;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    always_comb begin
        active_d    = active_q;
        sck_d       = sck_q;
        div_d       = div_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        half_end    = active_q && (div_q == DivLast);
        byte_done_o = half_end && sck_q && (bit_q == 3'd7);

        if (half_end) begin
            div_d = '0;
            if (!sck_q) begin
                sck_d = 1'b1;
                rx_d  = {rx_q[6:0], miso_i};
            end else begin
                // Shifting on the falling edge zero-fills, so MOSI rests low after the byte.
                sck_d = 1'b0;
                tx_d  = {tx_q[6:0], 1'b0};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    active_d = 1'b0;
                end
            end
        end else if (active_q) begin
            div_d = div_q + 1'b1;
        end

        // A load coinciding with byte_done chains bytes with no idle SCK period.
        if (load_i) begin
            active_d = 1'b1;
            sck_d    = 1'b0;
            div_d    = '0;
            bit_d    = '0;
            tx_d     = tx_byte_i;
        end
    end

    assign sck_o     = sck_q;
    assign mosi_o    = tx_q[7];
    assign rx_byte_o = rx_q;

endmodule

// File: rtl/spi_page_programmer.sv
// Flash page write-back: WREN, Page Program of one 256-byte buffer page, then RDSR polling.
module spi_page_programmer
    import spi_flash_pkg::*;
#(
    parameter int unsigned SCK_HALF   = 2,
    parameter int unsigned CS_GAP     = 8,
    parameter int unsigned POLL_LIMIT = 8192
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic        START,
    input  logic [13:0] PAGEADDR,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        nBUFRCLKEN,
    output logic [7:0]  BUFRADDR,
    input  logic [7:0]  BUFRDATA,
    output logic        nCS,
    output logic        MOSI,
    input  logic        MISO,
    output logic        CLK
);

    localparam int unsigned GapW = $clog2(SCK_HALF + CS_GAP) + 1;
    localparam logic [GapW-1:0] CsRise   = GapW'(SCK_HALF - 1);
    localparam logic [GapW-1:0] GapLast  = GapW'(SCK_HALF + CS_GAP - 1);
    localparam logic [8:0]      LastByte = 9'(PAGE_SIZE + 3);
    localparam logic [13:0]     PollLim  = 14'(POLL_LIMIT);

    state_e          state_q, state_d;
    logic            cs_n_q, cs_n_d;
    logic [8:0]      byte_cnt_q, byte_cnt_d;
    logic [13:0]     poll_cnt_q, poll_cnt_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic [13:0]     page_q, page_d;
    logic            err_q, err_d;
    logic            ending_q, ending_d;
    logic            rd_en_n_q, rd_en_n_d;
    logic [7:0]      rd_addr_q, rd_addr_d;
    logic            cap_q, cap_d;
    logic [7:0]      data_q, data_d;

    logic            load;
    logic [7:0]      tx_byte;
    logic            byte_done;
    logic [7:0]      rx_byte;
    logic            start_ok;
    logic [8:0]      next_idx;
    logic [13:0]     poll_next;
    logic            unused_rx;

    spi_byte_shifter #(
        .SCK_HALF(SCK_HALF)
    ) u_shifter (
        .clk_i      (MCLK),
        .rst_ni     (nRESET),
        .load_i     (load),
        .tx_byte_i  (tx_byte),
        .miso_i     (MISO),
        .sck_o      (CLK),
        .mosi_o     (MOSI),
        .byte_done_o(byte_done),
        .rx_byte_o  (rx_byte)
    );

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            cs_n_q     <= 1'b1;
            byte_cnt_q <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            page_q     <= '0;
            err_q      <= 1'b0;
            ending_q   <= 1'b0;
            rd_en_n_q  <= 1'b1;
            rd_addr_q  <= '0;
            cap_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            byte_cnt_q <= byte_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            page_q     <= page_d;
            err_q      <= err_d;
            ending_q   <= ending_d;
            rd_en_n_q  <= rd_en_n_d;
            rd_addr_q  <= rd_addr_d;
            cap_q      <= cap_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        byte_cnt_d = byte_cnt_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        page_d     = page_q;
        err_d      = err_q;
        ending_d   = ending_q;
        rd_en_n_d  = 1'b1;
        rd_addr_d  = rd_addr_q;
        cap_d      = !rd_en_n_q;
        data_d     = cap_q ? BUFRDATA : data_q;
        load       = 1'b0;
        tx_byte    = 8'h00;
        start_ok   = START && !BUSY;
        next_idx   = byte_cnt_q + 9'd1;
        poll_next  = (poll_cnt_q == PollLim) ? poll_cnt_q : poll_cnt_q + 14'd1;

        unique case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start_ok) begin
                    state_d = WREN;
                    page_d  = PAGEADDR;
                    err_d   = 1'b0;
                    cs_n_d  = 1'b0;
                    load    = 1'b1;
                    tx_byte = OP_WREN;
                end
            end
            WREN: begin
                if (byte_done) begin
                    state_d   = GAP1;
                    gap_cnt_d = '0;
                end
            end
            GAP1, GAP2: begin
                // nCS holds low SCK_HALF cycles past the last falling edge, then high CS_GAP cycles.
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == CsRise) begin
                    cs_n_d = 1'b1;
                end
                if (gap_cnt_q == GapLast) begin
                    cs_n_d     = 1'b0;
                    load       = 1'b1;
                    byte_cnt_d = '0;
                    if (state_q == GAP1) begin
                        state_d = PP;
                        tx_byte = OP_PP;
                    end else begin
                        state_d    = POLL;
                        tx_byte    = OP_RDSR;
                        poll_cnt_d = '0;
                    end
                end
            end
            PP: begin
                if (byte_done) begin
                    if (byte_cnt_q == LastByte) begin
                        state_d   = GAP2;
                        gap_cnt_d = '0;
                    end else begin
                        byte_cnt_d = next_idx;
                        load       = 1'b1;
                        case (next_idx)
                            9'd1:    tx_byte = {2'b00, page_q[13:8]};
                            9'd2:    tx_byte = page_q[7:0];
                            9'd3:    tx_byte = 8'h00;
                            default: tx_byte = data_q;
                        endcase
                        // Fetch the buffer byte needed by the frame byte after this one.
                        if (next_idx >= 9'd3 && next_idx < LastByte) begin
                            rd_en_n_d = 1'b0;
                            rd_addr_d = 8'(next_idx - 9'd3);
                        end
                    end
                end
            end
            POLL: begin
                if (ending_q) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                    if (gap_cnt_q == CsRise) begin
                        cs_n_d = 1'b1;
                    end
                    if (gap_cnt_q == GapLast) begin
                        state_d  = FIN;
                        ending_d = 1'b0;
                    end
                end else if (byte_done) begin
                    if (byte_cnt_q == 9'd0) begin
                        byte_cnt_d = 9'd1;
                        load       = 1'b1;
                    end else begin
                        poll_cnt_d = poll_next;
                        if (!rx_byte[0]) begin
                            ending_d  = 1'b1;
                            gap_cnt_d = '0;
                        end else if (poll_next == PollLim) begin
                            ending_d  = 1'b1;
                            gap_cnt_d = '0;
                            err_d     = 1'b1;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign unused_rx  = ^rx_byte[7:1];

    assign BUSY       = (state_q != IDLE) && (state_q != FIN);
    assign DONE       = (state_q == FIN);
    assign ERR        = err_q;
    assign nCS        = cs_n_q;
    assign nBUFRCLKEN = rd_en_n_q;
    assign BUFRADDR   = rd_addr_q;

endmodule

// File: tb/tb_spi_page_programmer.sv
// Directed bench: SPI slave monitor, flash status model and page-buffer model vs spec rules.
module tb_spi_page_programmer;

    localparam int SCK_HALF   = 2;
    localparam int CS_GAP     = 8;
    localparam int POLL_LIMIT = 16;

    logic        MCLK = 1'b0;
    logic        nRESET;
    logic        START;
    logic [13:0] PAGEADDR;
    logic        BUSY, DONE, ERR, nBUFRCLKEN, nCS, MOSI, CLK;
    logic [7:0]  BUFRADDR;
    logic [7:0]  BUFRDATA;
    logic        MISO;

    spi_page_programmer #(
        .SCK_HALF  (SCK_HALF),
        .CS_GAP    (CS_GAP),
        .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .MCLK      (MCLK),
        .nRESET    (nRESET),
        .START     (START),
        .PAGEADDR  (PAGEADDR),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .nBUFRCLKEN(nBUFRCLKEN),
        .BUFRADDR  (BUFRADDR),
        .BUFRDATA  (BUFRDATA),
        .nCS       (nCS),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .CLK       (CLK)
    );

    always #5 MCLK = ~MCLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] mon_bytes[$];
    int         frame_first[$];
    int         frame_edges[$];
    logic [7:0] reads[$];
    bit         in_frame;
    int         cur_edges, cur_first;
    logic [7:0] cur_byte;
    int         cs_fall_cyc, cs_rise_cyc, last_fall_cyc;
    logic       prev_cs, prev_clk, prev_mosi;
    int         done_cnt;
    bit         rd_pend;
    logic [7:0] rd_addr;
    int         flash_busy_n;
    bit         flash_stuck;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic [7:0] status_byte(input int s);
        if (flash_stuck) return 8'hFF;
        return (s < flash_busy_n) ? 8'h03 : 8'h00;
    endfunction

    function automatic logic [7:0] exp_byte(input int f, input int j, input logic [13:0] page);
        if (f == 0) return 8'h06;
        if (f == 2) return (j == 0) ? 8'h05 : 8'h00;
        case (j)
            0:       return 8'h02;
            1:       return {2'b00, page[13:8]};
            2:       return page[7:0];
            3:       return 8'h00;
            default: return 8'(j - 4) ^ 8'hA5;
        endcase
    endfunction

    // Bus-level observer plus flash and buffer models, evaluated once per MCLK at the falling edge.
    task automatic observe();
        logic [7:0] st;
        if (!nRESET) begin
            in_frame  = 1'b0;
            rd_pend   = 1'b0;
            prev_cs   = nCS;
            prev_clk  = CLK;
            prev_mosi = MOSI;
            MISO      = 1'b0;
            return;
        end
        if (rd_pend) begin
            BUFRDATA = rd_addr ^ 8'hA5;
            rd_pend  = 1'b0;
        end
        if (!nBUFRCLKEN) begin
            rd_pend = 1'b1;
            rd_addr = BUFRADDR;
            reads.push_back(BUFRADDR);
        end
        if (DONE) done_cnt++;
        if (nCS) check("clk_idle_low_when_deselected", CLK, 0);
        if (MOSI != prev_mosi) check("mosi_changes_with_clk_low", CLK, 0);
        if (prev_cs && !nCS) begin
            if (frame_edges.size() > 0) check("cs_high_gap", int'(cyc - cs_rise_cyc >= CS_GAP), 1);
            in_frame    = 1'b1;
            cur_edges   = 0;
            cur_first   = mon_bytes.size();
            cs_fall_cyc = cyc;
        end
        if (in_frame && !prev_clk && CLK) begin
            if (cur_edges == 0) check("cs_lead", int'(cyc - cs_fall_cyc >= SCK_HALF), 1);
            cur_byte = {cur_byte[6:0], MOSI};
            cur_edges++;
            if (cur_edges % 8 == 0) mon_bytes.push_back(cur_byte);
        end
        if (prev_clk && !CLK) last_fall_cyc = cyc;
        if (in_frame && !prev_cs && nCS) begin
            check("cs_tail", int'(cyc - last_fall_cyc >= SCK_HALF), 1);
            frame_first.push_back(cur_first);
            frame_edges.push_back(cur_edges);
            in_frame    = 1'b0;
            cs_rise_cyc = cyc;
        end
        // Flash changes MISO only while SCK is low; status bytes follow an RDSR opcode.
        if (!nCS && !CLK) begin
            MISO = 1'b0;
            if (in_frame && cur_edges >= 8 && mon_bytes[cur_first] == 8'h05) begin
                st   = status_byte((cur_edges - 8) / 8);
                MISO = st[7 - ((cur_edges - 8) % 8)];
            end
        end
        prev_cs   = nCS;
        prev_clk  = CLK;
        prev_mosi = MOSI;
    endtask

    task automatic tick();
        @(negedge MCLK);
        cyc++;
        observe();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ncs"}, nCS, 1);
        check({tag, "_clk"}, CLK, 0);
        check({tag, "_mosi"}, MOSI, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_err"}, ERR, 0);
        check({tag, "_nbufrclken"}, nBUFRCLKEN, 1);
        check({tag, "_bufraddr"}, BUFRADDR, 0);
    endtask

    task automatic check_frames(input logic [13:0] page, input int n_stat);
        int exp_edges, bad, nb;
        check("frame_count", frame_edges.size(), 3);
        if (frame_edges.size() != 3) return;
        for (int f = 0; f < 3; f++) begin
            exp_edges = (f == 0) ? 8 : (f == 1) ? 2080 : 8 * (1 + n_stat);
            check($sformatf("frame%0d_rising_edges", f), frame_edges[f], exp_edges);
            bad = -1;
            nb  = frame_edges[f] / 8;
            for (int j = 0; j < nb; j++) begin
                if (mon_bytes[frame_first[f] + j] !== exp_byte(f, j, page)) begin
                    bad = j;
                    break;
                end
            end
            check($sformatf("frame%0d_first_bad_byte_index", f), bad, -1);
        end
    endtask

    task automatic run_op(input logic [13:0] page, input int n_busy, input bit stuck,
                          input bit disturb, input int exp_err, input int exp_stat);
        bit got;
        int bad;
        mon_bytes.delete();
        frame_first.delete();
        frame_edges.delete();
        reads.delete();
        done_cnt     = 0;
        flash_busy_n = n_busy;
        flash_stuck  = stuck;
        PAGEADDR     = page;
        START        = 1'b1;
        tick();
        START = 1'b0;
        check("busy_after_start", BUSY, 1);
        check("err_cleared_on_start", ERR, 0);
        got = 1'b0;
        for (int i = 0; i < 20000 && !got; i++) begin
            if (disturb && (i == 10 || i == 1200)) begin
                START    = 1'b1;
                PAGEADDR = 14'h3FFF;
            end else begin
                START = 1'b0;
            end
            tick();
            if (DONE) got = 1'b1;
        end
        START = 1'b0;
        check("done_seen_within_bound", got, 1);
        if (got) begin
            check("busy_low_with_done", BUSY, 0);
            check("err_at_done", ERR, exp_err);
        end
        tick();
        check("done_single_cycle", DONE, 0);
        repeat (20) tick();
        check("done_count", done_cnt, 1);
        check("err_held", ERR, exp_err);
        check_frames(page, exp_stat);
        check("buf_read_count", reads.size(), 256);
        bad = -1;
        for (int i = 0; i < reads.size(); i++) begin
            if (reads[i] !== 8'(i)) begin
                bad = i;
                break;
            end
        end
        check("buf_read_order_first_bad", bad, -1);
    endtask

    initial begin
        bit reached;
        nRESET   = 1'b0;
        START    = 1'b0;
        PAGEADDR = '0;
        BUFRDATA = 8'h00;
        MISO     = 1'b0;
        in_frame = 1'b0;
        prev_cs  = 1'b1;
        prev_clk = 1'b0;
        prev_mosi = 1'b0;
        cur_byte = '0;
        #12;
        check_reset_outputs("por");
        tick();
        nRESET = 1'b1;
        tick();

        // Full sequence, three busy polls then ready; literal pins on the PP frame.
        run_op(14'h0123, 3, 1'b0, 1'b0, 0, 4);
        if (frame_edges.size() == 3 && frame_edges[1] == 2080) begin
            check("pp_byte1", mon_bytes[frame_first[1] + 1], 8'h01);
            check("pp_byte2", mon_bytes[frame_first[1] + 2], 8'h23);
            check("pp_byte4", mon_bytes[frame_first[1] + 4], 8'hA5);
            check("pp_byte5", mon_bytes[frame_first[1] + 5], 8'hA4);
            check("pp_byte259", mon_bytes[frame_first[1] + 259], 8'h5A);
        end

        // Poll timeout with WIP stuck; the following op checks ERR clears on accept.
        run_op(14'h2AAA, 0, 1'b1, 1'b0, 1, 16);

        // START pulses while busy are ignored.
        run_op(14'h1555, 1, 1'b0, 1'b1, 0, 2);

        // Reset in the middle of the PP frame.
        PAGEADDR = 14'h0040;
        START    = 1'b1;
        tick();
        START   = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 5000 && !reached; i++) begin
            tick();
            if (frame_edges.size() >= 1 && in_frame && cur_edges >= 200) reached = 1'b1;
        end
        check("reached_mid_pp", reached, 1);
        nRESET = 1'b0;
        #1;
        check_reset_outputs("midpp_rst");
        tick();
        nRESET = 1'b1;
        tick();
        run_op(14'h3FFF, 0, 1'b0, 1'b0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_page_programmer.md
Name: spi_page_programmer

Overview:
Flash write-back engine. It is the writer counterpart to the SPILoader read path and shares the W25Q32 SPI pins through an external mux owned by the top level. On a START pulse it programs one 256-byte flash page from a synchronous page buffer using the sequence WREN (0x06), Page Program (0x02) with a 24-bit address and 256 data bytes, then continuous RDSR (0x05) polling until WIP clears. It reports DONE, or ERR on poll timeout.

Parameters:
SCK_HALF, 2, MCLK cycles per SCK half-period (2 gives 12 MHz SCK from 48 MHz).
CS_GAP, 8, minimum MCLK cycles nCS stays high between frames.
POLL_LIMIT, 8192, maximum status bytes read before timeout.

Ports:
MCLK  in  1  48 MHz clock.
nRESET  in  1  asynchronous, active-low reset.
START  in  1  one-cycle request pulse; ignored while BUSY=1.
PAGEADDR  in  14  flash page number; byte address = {2'b00, PAGEADDR, 8'h00}.
BUSY  out  1  high from the cycle after an accepted START until the DONE cycle.
DONE  out  1  one-cycle completion pulse.
ERR  out  1  poll timeout flag, held until the next accepted START.
nBUFRCLKEN  out  1  active-low page-buffer read enable.
BUFRADDR  out  8  page-buffer byte index.
BUFRDATA  in  8  page-buffer data, valid 1 MCLK after the nBUFRCLKEN low cycle.
nCS  out  1  flash chip select.
MOSI  out  1  flash data in.
MISO  in  1  flash data out.
CLK  out  1  flash SCK.

Behaviour:
- Clock and reset: the block has one clock, MCLK, and one reset, nRESET. nRESET is asynchronous and active-low.
- Reset values: nCS=1, CLK=0, MOSI=0, BUSY=0, DONE=0, ERR=0, nBUFRCLKEN=1, BUFRADDR=0. All state returns to IDLE.
- Reset mid-operation: nCS rises asynchronously with reset. If the PP frame is cut short, the flash discards it (not on a byte boundary); no further action is required.
- SPI mode 0:
  - CLK idles low.
  - MOSI is driven MSB-first and changes only while CLK is low.
  - MISO is sampled on each CLK rising edge.
  - One byte takes 16*SCK_HALF MCLK cycles.
  - nCS falls at least SCK_HALF cycles before the first rising edge and rises at least SCK_HALF cycles after the last falling edge.
- Accepting START: START with BUSY=0 latches PAGEADDR, clears ERR and sets BUSY on the next cycle.
- States:
  - IDLE -> WREN on an accepted START.
  - WREN: one frame sending 0x06 (8 SCK edges) -> GAP1.
  - GAP1: nCS high for CS_GAP cycles -> PP.
  - PP: one frame sending 0x02, ADDR[23:16], ADDR[15:8], 0x00, then buffer bytes 0..255. That is 260 bytes, 2080 rising edges.
    - Buffer prefetch: for byte i, nBUFRCLKEN is low for exactly one cycle with BUFRADDR=i, completed before byte i's first bit is driven.
    - Each index 0..255 is read exactly once, in ascending order. The byte is latched into the shifter.
    - After the last byte -> GAP2.
  - GAP2: CS_GAP cycles high -> POLL.
  - POLL: one frame sending 0x05, then continuous status bytes (MOSI=0), keeping nCS low.
    - After each status byte: if bit0 (WIP)=0, end the frame and go to FIN.
    - Otherwise, if the status-byte count equals POLL_LIMIT, end the frame, set ERR and go to FIN.
  - FIN: DONE=1 and BUSY=0 in the same cycle -> IDLE.
- Counters:
  - Byte counter: 9 bits, range 0..259.
  - Poll counter: 14 bits, saturates at POLL_LIMIT.
  - Bit counter: 3 bits. Divider: log2(SCK_HALF)+1 bits.
- Buffer contents are never modified. Software must not change the buffer while BUSY=1.

Decomposition:
- Package spi_flash_pkg holds:
  - opcodes OP_WREN=8'h06, OP_PP=8'h02, OP_RDSR=8'h05, OP_READ=8'h03 (OP_READ shared with SPILoader);
  - the page-size constant 256;
  - the state enum {IDLE, WREN, GAP1, PP, GAP2, POLL, FIN}.
- Sub-module spi_byte_shifter, which owns the SCK divider, bit counter, MOSI shift-out and MISO shift-in.
  - Interface: LOAD/TXBYTE in, BYTEDONE pulse and RXBYTE out.
  - The parent FSM controls nCS and byte sequencing.

Test Plan:
1. Reset check: assert nRESET=0 mid-PP frame -> nCS=1 within the same cycle. All outputs are at reset values, and the next START runs the full sequence cleanly.
2. WREN frame: START with PAGEADDR=14'h0123 -> first nCS-low window has exactly 8 rising edges with MOSI bits 0x06, followed by nCS high for at least 8 MCLK.
3. PP frame: buffer model returns BUFRDATA = addr^8'hA5 -> frame bytes are 0x02,0x01,0x23,0x00,0xA5,0xA4,...,0x5A. There are exactly 2080 rising edges. BUFRADDR strobes 0..255 once each, with nBUFRCLKEN pulses exactly 256.
4. Poll success: MISO model returns status 0x03 three times, then 0x00 -> exactly 4 status bytes are read. DONE pulses 1 cycle with BUSY falling the same cycle, and ERR=0.
5. Poll timeout: MISO stuck at 1, POLL_LIMIT=16 -> 16 status bytes then nCS high. DONE pulses with ERR=1, and ERR clears on the next accepted START.
6. START pulses during BUSY (at 10 cycles and mid-PP) -> ignored. The transfer is unaltered, and exactly one DONE occurs.
